ni_packetizer: RTL and testbench
================================

Name: ni_packetizer

Overview:
Network-interface injection stage that sits directly upstream of the NI 64-bit FIFO. It accepts a packet request from the local core (destination plus payload length), then a stream of payload words. It emits one head flit followed by body/tail flits into the FIFO, honouring `full` as backpressure. Flit type travels in the two MSBs, so payload words are DATA_W-2 bits.

Parameters:
- DATA_W, 64, flit width; must equal the FIFO data width.
- COORD_W, 4, width of each mesh coordinate.
- LEN_W, 8, width of the payload-length field, in flits.
- ID_W, 8, width of the packet sequence ID.
- SRC_X, 0, this node's X coordinate, inserted into head flits.
- SRC_Y, 0, this node's Y coordinate, inserted into head flits.

Ports:
- clk  in  1  system clock; rising edge.
- reset  in  1  asynchronous reset, active-low (0 = reset).
- req_valid  in  1  core presents a packet request.
- req_ready  out  1  packetizer can accept a request.
- req_dest_x  in  COORD_W  destination X.
- req_dest_y  in  COORD_W  destination Y.
- req_len  in  LEN_W  number of payload flits (0..2^LEN_W-1).
- pl_valid  in  1  payload word valid.
- pl_ready  out  1  payload word accepted this cycle.
- pl_data  in  DATA_W-2  payload word.
- fifo_write_en  out  1  drives FIFO write_en.
- fifo_data_in  out  DATA_W  drives FIFO data_in.
- fifo_full  in  1  FIFO full flag.
- busy  out  1  a packet is in progress (state != IDLE).

Behaviour:
- Flit type in [DATA_W-1:DATA_W-2]: 00 HEAD, 01 BODY, 10 TAIL, 11 HEAD_TAIL (zero-length packet).
- Head flit fields, MSB-down from bit 61: dest_x, dest_y, src_x, src_y, len, pkt_id; all remaining LSBs are 0.
- Body/tail flit: type bits followed by pl_data.
- FSM states: IDLE, HEAD, PAYLOAD.
- IDLE:
  - req_ready=1.
  - When req_valid=1, latch dest, len and the current pkt_id; go to HEAD.
- HEAD:
  - req_ready=0.
  - fifo_write_en = !fifo_full.
  - On a write, go to PAYLOAD with cnt=0. If len==0, the flit type is HEAD_TAIL, pkt_id increments and the FSM returns to IDLE.
- PAYLOAD:
  - pl_ready = !fifo_full.
  - fifo_write_en = pl_valid & !fifo_full.
  - Each write increments cnt. The flit is BODY while cnt<len-1 and TAIL when cnt==len-1.
  - After TAIL, pkt_id increments and the FSM returns to IDLE.
- Latency: head is written no earlier than the cycle after the request is accepted. A back-to-back packet costs exactly one IDLE cycle between the tail and the next head.
- fifo_write_en, pl_ready and fifo_data_in are combinational from state/regs; all registers update on the clk rising edge.
- fifo_full=1: no write and no pl_ready; state and cnt hold. The flit is re-presented unchanged when full deasserts.
- pl_valid=0 in PAYLOAD: no write; state holds indefinitely; no timeout.
- pkt_id wraps from 2^ID_W-1 to 0.
- req_valid outside IDLE is ignored: no latch and req_ready stays 0.
- Reset, at any time including mid-packet:
  - state=IDLE, cnt=0, pkt_id=0, latched fields=0.
  - Outputs: req_ready=1, pl_ready=0, fifo_write_en=0, fifo_data_in=0, busy=0.
  - The partial packet is abandoned; flits already in the FIFO are the FIFO's concern.

Optional Feature:
- Macro: NI_PKT_CNT_EN.
- Defined: adds outputs pkt_count[15:0] and flit_count[15:0], both saturating and reset to 0.
  - pkt_count increments on each TAIL or HEAD_TAIL write.
  - flit_count increments on every FIFO write.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package ni_pkg holds:
  - the flit type constants (HEAD, BODY, TAIL, HEAD_TAIL);
  - the type-field bit positions;
  - the head-field offsets and widths, shared with the downstream depacketizer and router.
- One sub-module, ni_head_fmt: combinational; packs dest/src/len/id into a head flit. Reused by the router's test generators.

Test Plan:
- Reset mid-packet: drive reset=0 after the head and two bodies of a len=4 packet -> all outputs at reset values within the same cycle; the next request starts with pkt_id=0.
- Single packet: dest=(2,3), len=3, payloads 1,2,3, FIFO never full -> 4 writes, type sequence 00,01,01,10; head contains src (0,0), len=3, pkt_id=0.
- Zero-length packet: req_len=0 -> exactly one write of type 11; pkt_id becomes 1; req_ready=1 on the following cycle.
- Backpressure: len=2, fifo_full held high for 3 cycles during PAYLOAD -> no writes and pl_ready=0 during the stall; the identical flit is written once full drops; the total flit count is still 3.
- Payload bubbles: pl_valid toggles 1,0,0,1 with len=2 -> exactly 2 payload writes, the second typed TAIL; busy stays 1 until after the tail.
- ID wrap: send 257 zero-length packets -> the 257th head carries pkt_id=0. With NI_PKT_CNT_EN defined, pkt_count=257.

Source files
------------

// File: rtl/ni_pkg.sv
// ni_pkg: flit type codes, FSM state encoding and the head-flit field layout
// shared by the packetizer, depacketizer and router. Revision: 1.0
`default_nettype none

package ni_pkg;

  localparam int TYPE_W = 2;

  typedef enum logic [1:0] {
    FLIT_HEAD      = 2'b00,
    FLIT_BODY      = 2'b01,
    FLIT_TAIL      = 2'b10,
    FLIT_HEAD_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEAD    = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_e;

  // Head fields are packed MSB-down directly below the type bits:
  // dest_x, dest_y, src_x, src_y, len, pkt_id; remaining LSBs are zero.
  function automatic int hdr_type_lsb(input int data_w);
    return data_w - TYPE_W;
  endfunction

  function automatic int hdr_dest_x_lsb(input int data_w, input int coord_w);
    return data_w - TYPE_W - coord_w;
  endfunction

  function automatic int hdr_dest_y_lsb(input int data_w, input int coord_w);
    return data_w - TYPE_W - 2 * coord_w;
  endfunction

  function automatic int hdr_src_x_lsb(input int data_w, input int coord_w);
    return data_w - TYPE_W - 3 * coord_w;
  endfunction

  function automatic int hdr_src_y_lsb(input int data_w, input int coord_w);
    return data_w - TYPE_W - 4 * coord_w;
  endfunction

  function automatic int hdr_len_lsb(input int data_w, input int coord_w, input int len_w);
    return hdr_src_y_lsb(data_w, coord_w) - len_w;
  endfunction

  function automatic int hdr_id_lsb(input int data_w, input int coord_w, input int len_w,
                                    input int id_w);
    return hdr_len_lsb(data_w, coord_w, len_w) - id_w;
  endfunction

  // Reference layout for the standard 64-bit NI build.
  localparam int REF_DATA_W   = 64;
  localparam int REF_COORD_W  = 4;
  localparam int REF_LEN_W    = 8;
  localparam int REF_ID_W     = 8;
  localparam int REF_LEN_LSB  = hdr_len_lsb(REF_DATA_W, REF_COORD_W, REF_LEN_W);
  localparam int REF_ID_LSB   = hdr_id_lsb(REF_DATA_W, REF_COORD_W, REF_LEN_W, REF_ID_W);

endpackage

`default_nettype wire

// File: rtl/ni_head_fmt.sv
// ni_head_fmt: combinational head-flit formatter; zero length yields HEAD_TAIL.
// Revision: 1.0
`default_nettype none

module ni_head_fmt
  import ni_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int COORD_W = 4,
  parameter int LEN_W   = 8,
  parameter int ID_W    = 8
) (
  input  logic [COORD_W-1:0] dest_x,
  input  logic [COORD_W-1:0] dest_y,
  input  logic [COORD_W-1:0] src_x,
  input  logic [COORD_W-1:0] src_y,
  input  logic [LEN_W-1:0]   len,
  input  logic [ID_W-1:0]    pkt_id,
  output logic [DATA_W-1:0]  flit
);

  localparam int TYPE_LSB   = hdr_type_lsb(DATA_W);
  localparam int DEST_X_LSB = hdr_dest_x_lsb(DATA_W, COORD_W);
  localparam int DEST_Y_LSB = hdr_dest_y_lsb(DATA_W, COORD_W);
  localparam int SRC_X_LSB  = hdr_src_x_lsb(DATA_W, COORD_W);
  localparam int SRC_Y_LSB  = hdr_src_y_lsb(DATA_W, COORD_W);
  localparam int LEN_LSB    = hdr_len_lsb(DATA_W, COORD_W, LEN_W);
  localparam int ID_LSB     = hdr_id_lsb(DATA_W, COORD_W, LEN_W, ID_W);

  flit_type_e head_type;

  always_comb begin
    head_type = (len == '0) ? FLIT_HEAD_TAIL : FLIT_HEAD;
    flit = '0;
    flit[TYPE_LSB   +: TYPE_W]  = head_type;
    flit[DEST_X_LSB +: COORD_W] = dest_x;
    flit[DEST_Y_LSB +: COORD_W] = dest_y;
    flit[SRC_X_LSB  +: COORD_W] = src_x;
    flit[SRC_Y_LSB  +: COORD_W] = src_y;
    flit[LEN_LSB    +: LEN_W]   = len;
    flit[ID_LSB     +: ID_W]    = pkt_id;
  end

endmodule

`default_nettype wire

// File: rtl/ni_packetizer.sv
// ni_packetizer: NI injection stage turning a request plus payload stream into
// head/body/tail flits for the NI FIFO. Optional NI_PKT_CNT_EN adds counters. Revision: 1.0
`default_nettype none

module ni_packetizer
  import ni_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int COORD_W = 4,
  parameter int LEN_W   = 8,
  parameter int ID_W    = 8,
  parameter int SRC_X   = 0,
  parameter int SRC_Y   = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [COORD_W-1:0]  req_dest_x,
  input  logic [COORD_W-1:0]  req_dest_y,
  input  logic [LEN_W-1:0]    req_len,
  input  logic                pl_valid,
  output logic                pl_ready,
  input  logic [DATA_W-3:0]   pl_data,
  output logic                fifo_write_en,
  output logic [DATA_W-1:0]   fifo_data_in,
  input  logic                fifo_full,
  output logic                busy
`ifdef NI_PKT_CNT_EN
  ,
  output logic [15:0]         pkt_count,
  output logic [15:0]         flit_count
`endif
);

  localparam logic [COORD_W-1:0] SRC_X_C = COORD_W'(SRC_X);
  localparam logic [COORD_W-1:0] SRC_Y_C = COORD_W'(SRC_Y);

  state_e             state;
  logic [COORD_W-1:0] dest_x;
  logic [COORD_W-1:0] dest_y;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   cnt;
  logic [ID_W-1:0]    pkt_id;

  logic [DATA_W-1:0]  head_flit;
  logic               last;
  flit_type_e         pl_type;

  ni_head_fmt #(
    .DATA_W  (DATA_W),
    .COORD_W (COORD_W),
    .LEN_W   (LEN_W),
    .ID_W    (ID_W)
  ) u_head_fmt (
    .dest_x (dest_x),
    .dest_y (dest_y),
    .src_x  (SRC_X_C),
    .src_y  (SRC_Y_C),
    .len    (len),
    .pkt_id (pkt_id),
    .flit   (head_flit)
  );

  // len is never zero in PAYLOAD, so len-1 cannot underflow there.
  assign last    = (cnt == len - LEN_W'(1));
  assign pl_type = last ? FLIT_TAIL : FLIT_BODY;

  always_comb begin
    req_ready     = (state == ST_IDLE);
    busy          = (state != ST_IDLE);
    pl_ready      = 1'b0;
    fifo_write_en = 1'b0;
    fifo_data_in  = '0;
    case (state)
      ST_HEAD: begin
        fifo_write_en = !fifo_full;
        fifo_data_in  = head_flit;
      end
      ST_PAYLOAD: begin
        pl_ready      = !fifo_full;
        fifo_write_en = pl_valid && !fifo_full;
        fifo_data_in  = {pl_type, pl_data};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      dest_x <= '0;
      dest_y <= '0;
      len    <= '0;
      cnt    <= '0;
      pkt_id <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            dest_x <= req_dest_x;
            dest_y <= req_dest_y;
            len    <= req_len;
            state  <= ST_HEAD;
          end
        end
        ST_HEAD: begin
          if (fifo_write_en) begin
            cnt <= '0;
            if (len == '0) begin
              pkt_id <= pkt_id + ID_W'(1);
              state  <= ST_IDLE;
            end else begin
              state  <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (fifo_write_en) begin
            if (last) begin
              cnt    <= '0;
              pkt_id <= pkt_id + ID_W'(1);
              state  <= ST_IDLE;
            end else begin
              cnt    <= cnt + LEN_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef NI_PKT_CNT_EN
  logic pkt_done;

  assign pkt_done = fifo_write_en &&
                    (((state == ST_HEAD) && (len == '0)) || ((state == ST_PAYLOAD) && last));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_count  <= '0;
      flit_count <= '0;
    end else begin
      if (pkt_done && (pkt_count != 16'hFFFF)) begin
        pkt_count <= pkt_count + 16'd1;
      end
      if (fifo_write_en && (flit_count != 16'hFFFF)) begin
        flit_count <= flit_count + 16'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ni_packetizer.sv
// tb_ni_packetizer: scoreboard bench for ni_packetizer (64-bit flit, 4-bit coords).
// Revision: 1.0
`default_nettype none

module tb_ni_packetizer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_dest_x = '0;
  logic [3:0]  req_dest_y = '0;
  logic [7:0]  req_len = '0;
  logic        pl_valid = 1'b0;
  logic        pl_ready;
  logic [61:0] pl_data = '0;
  logic        fifo_write_en;
  logic [63:0] fifo_data_in;
  logic        fifo_full = 1'b0;
  logic        busy;
`ifdef NI_PKT_CNT_EN
  logic [15:0] pkt_count;
  logic [15:0] flit_count;
`endif

  int          total = 0;
  int          bad = 0;
  int          writes = 0;
  int          cyc = 0;
  int          wcyc_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;
  logic [7:0]  exp_id = '0;

  always #5 clk = ~clk;

  ni_packetizer #(
    .DATA_W  (64),
    .COORD_W (4),
    .LEN_W   (8),
    .ID_W    (8),
    .SRC_X   (0),
    .SRC_Y   (0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dest_x    (req_dest_x),
    .req_dest_y    (req_dest_y),
    .req_len       (req_len),
    .pl_valid      (pl_valid),
    .pl_ready      (pl_ready),
    .pl_data       (pl_data),
    .fifo_write_en (fifo_write_en),
    .fifo_data_in  (fifo_data_in),
    .fifo_full     (fifo_full),
    .busy          (busy)
`ifdef NI_PKT_CNT_EN
    ,
    .pkt_count     (pkt_count),
    .flit_count    (flit_count)
`endif
  );

  function automatic logic [63:0] head_flit(input logic [3:0] dx, input logic [3:0] dy,
                                            input logic [7:0] ln, input logic [7:0] id);
    logic [63:0] f;
    f = '0;
    f[63:62] = (ln == 8'd0) ? 2'b11 : 2'b00;
    f[61:58] = dx;
    f[57:54] = dy;
    f[53:50] = 4'd0;
    f[49:46] = 4'd0;
    f[45:38] = ln;
    f[37:30] = id;
    return f;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Every FIFO write is checked against the oldest expected flit.
  always @(negedge clk) begin
    if (reset && fifo_write_en) begin
      writes = writes + 1;
      wcyc_q.push_back(cyc);
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL flit_unexpected got=%h exp=<none>", fifo_data_in);
      end else begin
        mon_exp = exp_q.pop_front();
        if (fifo_data_in !== mon_exp) begin
          bad = bad + 1;
          $display("FAIL flit got=%h exp=%h", fifo_data_in, mon_exp);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_req_ready();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL req_ready_timeout got=0 exp=1");
    end
  endtask

  task automatic wait_writes(input int target);
    int n = 0;
    while (writes < target && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (writes < target) begin
      total++; bad++;
      $display("FAIL write_timeout got=%0d exp=%0d", writes, target);
    end
  endtask

  // Issues one request and feeds nfeed payload words, with optional bubbles.
  task automatic send_pkt(input logic [3:0] dx, input logic [3:0] dy, input logic [7:0] ln,
                          input int nfeed, input int bubbles, input bit fixed);
    logic [61:0] d;
    int n;
    wait_req_ready();
    req_dest_x = dx;
    req_dest_y = dy;
    req_len    = ln;
    req_valid  = 1'b1;
    exp_q.push_back(head_flit(dx, dy, ln, exp_id));
    exp_id++;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < nfeed; i++) begin
      if (i > 0) begin
        for (int b = 0; b < bubbles; b++) begin
          pl_valid = 1'b0;
          @(posedge clk); #1;
          total++;
          if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_in_bubble got=%b exp=1", busy);
          end
        end
      end
      d = fixed ? 62'(i + 1) : 62'({$urandom, $urandom});
      pl_data  = d;
      pl_valid = 1'b1;
      exp_q.push_back({(i == int'(ln) - 1) ? 2'b10 : 2'b01, d});
      n = 0;
      @(negedge clk);
      while (!pl_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!pl_ready) begin
        total++; bad++;
        $display("FAIL pl_ready_timeout got=0 exp=1");
      end
      @(posedge clk); #1;
    end
    pl_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({req_ready, pl_ready, fifo_write_en, busy} !== 4'b1000 || fifo_data_in !== 64'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b%b%b%b/%h exp=1000/0", req_ready, pl_ready,
               fifo_write_en, busy, fifo_data_in);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset_mid();
    int w0 = writes;
    send_pkt(4'd1, 4'd1, 8'd4, 2, 0, 1'b0);
    total++;
    if (writes - w0 !== 3) begin
      bad++;
      $display("FAIL reset_mid_writes got=%0d exp=3", writes - w0);
    end
    pl_valid = 1'b1;
    #1;
    total++;
    if (busy !== 1'b1 || pl_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_pre got=%b%b exp=11", busy, pl_ready);
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({req_ready, pl_ready, fifo_write_en, busy} !== 4'b1000 || fifo_data_in !== 64'd0) begin
      bad++;
      $display("FAIL reset_mid_outputs got=%b%b%b%b/%h exp=1000/0", req_ready, pl_ready,
               fifo_write_en, busy, fifo_data_in);
    end
    exp_q.delete();
    exp_id   = '0;
    pl_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single();
    int w0 = writes;
    send_pkt(4'd2, 4'd3, 8'd3, 3, 0, 1'b1);
    total++;
    if (writes - w0 !== 4) begin
      bad++;
      $display("FAIL single_writes got=%0d exp=4", writes - w0);
    end
  endtask

  task automatic test_zero_len();
    int w0 = writes;
    send_pkt(4'd5, 4'd6, 8'd0, 0, 0, 1'b0);
    @(negedge clk);
    total++;
    if (fifo_write_en !== 1'b1 || fifo_data_in[63:62] !== 2'b11) begin
      bad++;
      $display("FAIL zero_len_write got=%b/%b exp=1/11", fifo_write_en, fifo_data_in[63:62]);
    end
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || fifo_write_en !== 1'b0 || writes - w0 !== 1) begin
      bad++;
      $display("FAIL zero_len_after got=%b%b/%0d exp=10/1", req_ready, fifo_write_en, writes - w0);
    end
  endtask

  task automatic test_backpressure();
    int w0 = writes;
    logic [63:0] held;
    fork
      send_pkt(4'd7, 4'd1, 8'd2, 2, 0, 1'b0);
      begin
        wait_writes(w0 + 1);
        fifo_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          if (k == 0) held = fifo_data_in;
          total++;
          if (fifo_write_en !== 1'b0 || pl_ready !== 1'b0 || fifo_data_in !== held) begin
            bad++;
            $display("FAIL stall got=%b%b/%h exp=00/%h", fifo_write_en, pl_ready,
                     fifo_data_in, held);
          end
        end
        @(posedge clk); #1;
        fifo_full = 1'b0;
        @(negedge clk);
        total++;
        if (fifo_write_en !== 1'b1 || fifo_data_in !== held) begin
          bad++;
          $display("FAIL stall_release got=%b/%h exp=1/%h", fifo_write_en, fifo_data_in, held);
        end
      end
    join
    wait_writes(w0 + 3);
    @(posedge clk); #1;
    total++;
    if (writes - w0 !== 3) begin
      bad++;
      $display("FAIL backpressure_writes got=%0d exp=3", writes - w0);
    end
  endtask

  task automatic test_bubbles();
    int w0 = writes;
    send_pkt(4'd3, 4'd9, 8'd2, 2, 2, 1'b0);
    total++;
    if (writes - w0 !== 3 || busy !== 1'b0) begin
      bad++;
      $display("FAIL bubbles got=%0d/%b exp=3/0", writes - w0, busy);
    end
  endtask

  // Holds req_valid so packets follow each other as tightly as the FSM allows.
  task automatic run_held(input int npkt, input logic [7:0] ln, input logic [61:0] d);
    int n;
    wait_req_ready();
    req_dest_x = 4'd10;
    req_dest_y = 4'd11;
    req_len    = ln;
    pl_data    = d;
    pl_valid   = (ln != 8'd0);
    req_valid  = 1'b1;
    wcyc_q.delete();
    for (int k = 0; k < npkt; k++) begin
      exp_q.push_back(head_flit(4'd10, 4'd11, ln, exp_id));
      exp_id++;
      if (ln != 8'd0) exp_q.push_back({2'b10, d});
    end
    for (int k = 0; k < npkt; k++) begin
      n = 0;
      while (!req_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk); #1;
      if (k == npkt - 1) req_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int w0 = writes;
    int g;
    run_held(3, 8'd1, 62'h1234_5678_9ABC);
    wait_writes(w0 + 6);
    pl_valid = 1'b0;
    for (int k = 1; k < 6; k++) begin
      g = (k < wcyc_q.size()) ? wcyc_q[k] - wcyc_q[k-1] : -1;
      total++;
      if (g !== ((k % 2 == 1) ? 1 : 2)) begin
        bad++;
        $display("FAIL b2b_gap%0d got=%0d exp=%0d", k, g, (k % 2 == 1) ? 1 : 2);
      end
    end
  endtask

  task automatic test_id_wrap();
    int w0;
    int g;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    exp_q.delete();
    exp_id = '0;
    reset  = 1'b1;
    w0 = writes;
    run_held(257, 8'd0, 62'd0);
    wait_writes(w0 + 257);
    @(posedge clk); #1;
    total++;
    if (wcyc_q.size() !== 257) begin
      bad++;
      $display("FAIL wrap_count got=%0d exp=257", wcyc_q.size());
    end
    for (int k = 1; k < wcyc_q.size(); k++) begin
      g = wcyc_q[k] - wcyc_q[k-1];
      total++;
      if (g !== 2) begin
        bad++;
        $display("FAIL wrap_gap%0d got=%0d exp=2", k, g);
      end
    end
`ifdef NI_PKT_CNT_EN
    total++;
    if (pkt_count !== 16'd257 || flit_count !== 16'd257) begin
      bad++;
      $display("FAIL counters got=%0d/%0d exp=257/257", pkt_count, flit_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_single();
    test_zero_len();
    test_backpressure();
    test_bubbles();
    test_back_to_back();
    test_id_wrap();
    repeat (3) @(posedge clk);
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
